crc_ci_engine: RTL and testbench

Multi-channel, multi-cycle CRC engine attached to the Nios II as a custom instruction, the successor to the single-context CRC wrapper. It holds CHANNELS independent CRC contexts of parametrised width and polynomial. Data is processed one byte per clock under a start/done handshake. Contexts support save/restore, so the OS can share channels between tasks.

---
 rtl/crc_ci_engine.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_crc_ci_engine.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_ci_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : crc_ci_engine                                                 |
// | Purpose  : Multi-channel, multi-cycle CRC engine for the Nios II custom  |
// |            instruction port. Holds CHANNELS independent CRC contexts,    |
// |            processes one byte per enabled clock and supports context     |
// |            save (RDRAW) / restore (LOAD).                                |
// | Ports    : clk     - clock                                               |
// |            reset   - asynchronous, active-high reset                     |
// |            clk_en  - custom-instruction clock enable (low = stall)       |
// |            start   - instruction start strobe                            |
// |            n       - [2:0] opcode, [5:3] channel, [7:6] ignored          |
// |            dataa   - write data / restore value                          |
// |            done    - one-cycle completion strobe                         |
// |            result  - registered result, zero-extended above CRC_WIDTH    |
// | Options  : `define CRC_CI_BYTECOUNT_EN adds a 32-bit per-channel byte    |
// |            counter readable with opcode 7 (otherwise opcode 7 reads 0).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module crc_ci_engine #(
  parameter int          CRC_WIDTH   = 32,
  parameter logic [31:0] POLY        = 32'h04C11DB7,
  parameter logic [31:0] INIT        = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT     = 32'hFFFFFFFF,
  parameter bit          REFLECT_IN  = 1'b1,
  parameter bit          REFLECT_OUT = 1'b1,
  parameter int          CHANNELS    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [7:0]  n,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [CRC_WIDTH-1:0] C_POLY = POLY[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] C_INIT = INIT[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] C_XOR  = XOR_OUT[CRC_WIDTH-1:0];

  localparam logic [2:0] C_OP_INIT    = 3'd0;
  localparam logic [2:0] C_OP_WR8     = 3'd1;
  localparam logic [2:0] C_OP_WR16    = 3'd2;
  localparam logic [2:0] C_OP_WR32    = 3'd3;
  localparam logic [2:0] C_OP_RDFINAL = 3'd4;
  localparam logic [2:0] C_OP_RDRAW   = 3'd5;
  localparam logic [2:0] C_OP_LOAD    = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ------------------------------------------------------------------------
  // Helper functions
  // ------------------------------------------------------------------------
  function automatic logic [7:0] f_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] f_rev_crc(input logic [CRC_WIDTH-1:0] v);
    logic [CRC_WIDTH-1:0] r;
    for (int i = 0; i < CRC_WIDTH; i++) r[i] = v[CRC_WIDTH-1-i];
    return r;
  endfunction

  // One byte through an MSB-first register: byte enters the top 8 bits,
  // then eight unrolled shift/conditional-XOR steps.
  function automatic logic [CRC_WIDTH-1:0] f_byte_step(input logic [CRC_WIDTH-1:0] crc,
                                                       input logic [7:0]           b);
    logic [CRC_WIDTH-1:0] c;
    c = crc;
    c[CRC_WIDTH-1 -: 8] = c[CRC_WIDTH-1 -: 8] ^ (REFLECT_IN ? f_rev8(b) : b);
    for (int i = 0; i < 8; i++) begin
      c = c[CRC_WIDTH-1] ? ((c << 1) ^ C_POLY) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] f_zext(input logic [CRC_WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[CRC_WIDTH-1:0] = v;
    return r;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] f_final(input logic [CRC_WIDTH-1:0] v);
    return (REFLECT_OUT ? f_rev_crc(v) : v) ^ C_XOR;
  endfunction

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  state_t                              state_q, state_d;
  logic [2:0]                          op_q, op_d;
  logic [2:0]                          ch_q, ch_d;
  logic [31:0]                         data_q, data_d;
  logic [1:0]                          idx_q, idx_d;
  logic                                done_q, done_d;
  logic [31:0]                         result_q, result_d;
  logic [CHANNELS-1:0][CRC_WIDTH-1:0]  crc_q, crc_d;
`ifdef CRC_CI_BYTECOUNT_EN
  logic [CHANNELS-1:0][31:0]           cnt_q, cnt_d;
  logic [31:0]                         w_acc_cnt;
`endif

  logic [CHANNELS-1:0]   w_acc_hit;   // channel addressed by the incoming instruction
  logic [CHANNELS-1:0]   w_cur_hit;   // channel of the instruction in flight
  logic [CRC_WIDTH-1:0]  w_acc_crc;
  logic [CRC_WIDTH-1:0]  w_cur_crc;
  logic [7:0]            w_byte;
  logic [CRC_WIDTH-1:0]  w_step;
  logic [1:0]            w_last_idx;
  logic                  w_is_wr;
  logic                  w_unused;

  // n[7:6] carry no meaning for this engine
  assign w_unused = ^n[7:6];

  // Channel decode; an out-of-range channel simply matches nothing, which
  // makes every update a no-op and forces a zero result.
  always_comb begin
    w_acc_hit = '0;
    w_cur_hit = '0;
    w_acc_crc = '0;
    w_cur_crc = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_acc_hit[i] = (n[5:3] == 3'(i));
      w_cur_hit[i] = (ch_q == 3'(i));
      if (w_acc_hit[i]) w_acc_crc = crc_q[i];
      if (w_cur_hit[i]) w_cur_crc = crc_q[i];
    end
  end

`ifdef CRC_CI_BYTECOUNT_EN
  always_comb begin
    w_acc_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_acc_hit[i]) w_acc_cnt = cnt_q[i];
    end
  end
`endif

  // Bytes are consumed LSB first
  always_comb begin
    case (idx_q)
      2'd0:    w_byte = data_q[7:0];
      2'd1:    w_byte = data_q[15:8];
      2'd2:    w_byte = data_q[23:16];
      default: w_byte = data_q[31:24];
    endcase
  end

  always_comb begin
    case (op_q)
      C_OP_WR8:  w_last_idx = 2'd0;
      C_OP_WR16: w_last_idx = 2'd1;
      default:   w_last_idx = 2'd3;
    endcase
  end

  assign w_step  = f_byte_step(w_cur_crc, w_byte);
  assign w_is_wr = (n[2:0] == C_OP_WR8) || (n[2:0] == C_OP_WR16) || (n[2:0] == C_OP_WR32);

  // ------------------------------------------------------------------------
  // Next-state / datapath
  // ------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ch_d     = ch_q;
    data_d   = data_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    result_d = result_q;
    crc_d    = crc_q;
`ifdef CRC_CI_BYTECOUNT_EN
    cnt_d    = cnt_q;
`endif

    case (state_q)
      // DONE accepts a new start exactly like IDLE so that back-to-back
      // instructions see no idle bubble.
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          op_d   = n[2:0];
          ch_d   = n[5:3];
          data_d = dataa;
          idx_d  = 2'd0;
          if (w_is_wr) begin
            state_d = ST_BUSY;
          end else begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = '0;
            if (|w_acc_hit) begin
              case (n[2:0])
                C_OP_INIT: begin
                  for (int i = 0; i < CHANNELS; i++) begin
                    if (w_acc_hit[i]) begin
                      crc_d[i] = C_INIT;
`ifdef CRC_CI_BYTECOUNT_EN
                      cnt_d[i] = '0;
`endif
                    end
                  end
                  result_d = f_zext(C_INIT);
                end
                C_OP_RDFINAL: result_d = f_zext(f_final(w_acc_crc));
                C_OP_RDRAW:   result_d = f_zext(w_acc_crc);
                C_OP_LOAD: begin
                  for (int i = 0; i < CHANNELS; i++) begin
                    if (w_acc_hit[i]) crc_d[i] = dataa[CRC_WIDTH-1:0];
                  end
                  result_d = f_zext(dataa[CRC_WIDTH-1:0]);
                end
                default: begin
`ifdef CRC_CI_BYTECOUNT_EN
                  result_d = w_acc_cnt;
`else
                  result_d = '0;
`endif
                end
              endcase
            end
          end
        end
      end

      ST_BUSY: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (w_cur_hit[i]) begin
            crc_d[i] = w_step;
`ifdef CRC_CI_BYTECOUNT_EN
            cnt_d[i] = cnt_q[i] + 32'd1;
`endif
          end
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == w_last_idx) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = (|w_cur_hit) ? f_zext(w_step) : 32'd0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Registers; clk_en low freezes everything, including done and result.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      ch_q     <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      crc_q    <= {CHANNELS{C_INIT}};
`ifdef CRC_CI_BYTECOUNT_EN
      cnt_q    <= '0;
`endif
    end else if (clk_en) begin
      op_q     <= op_d;
      ch_q     <= ch_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      result_q <= result_d;
      crc_q    <= crc_d;
`ifdef CRC_CI_BYTECOUNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_crc_ci_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_crc_ci_engine                                              |
// | Purpose  : Self-checking bench for crc_ci_engine (CRC-32 default build   |
// |            plus a CRC-16/CCITT instance), scoreboard driven.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_crc_ci_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic        start16;
  logic [7:0]  n;
  logic [31:0] dataa;
  logic        done, done16;
  logic [31:0] result, result16;

  crc_ci_engine u_dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .n      (n),
    .dataa  (dataa),
    .done   (done),
    .result (result)
  );

  crc_ci_engine #(
    .CRC_WIDTH   (16),
    .POLY        (32'h00001021),
    .INIT        (32'h0000FFFF),
    .XOR_OUT     (32'h00000000),
    .REFLECT_IN  (1'b0),
    .REFLECT_OUT (1'b0),
    .CHANNELS    (1)
  ) u_dut16 (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start16),
    .n      (n),
    .dataa  (dataa),
    .done   (done16),
    .result (result16)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;

  // Reference model: CRC-32 kept in reflected (LSB-first) form per channel
  logic [31:0] m_crc [4];
  logic [31:0] m_cnt [4];
  logic [15:0] m16;
  logic [32:0] sb_q [$];   // {check_enable, expected_result}

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = v[31-k];
    return r;
  endfunction

  function automatic logic [31:0] m_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [15:0] m16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int k = 7; k >= 0; k--) begin
      fb = r[15] ^ b[k];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_crc[c] = 32'hFFFFFFFF;
      m_cnt[c] = 32'd0;
    end
    m16 = 16'hFFFF;
  endtask

  // Update the CRC-32 model and push the expected result to the scoreboard
  task automatic model_op(input logic [2:0] op, input logic [2:0] ch, input logic [31:0] d);
    logic [31:0] e;
    bit          chk;
    int          k;
    e = 32'd0;
    chk = 1'b1;
    if (ch < 3'd4) begin
      case (op)
        3'd0: begin m_crc[ch] = 32'hFFFFFFFF; m_cnt[ch] = 32'd0; chk = 1'b0; end
        3'd1, 3'd2, 3'd3: begin
          k = (op == 3'd1) ? 1 : (op == 3'd2) ? 2 : 4;
          for (int b = 0; b < k; b++) begin
            m_crc[ch] = m_byte(m_crc[ch], d[8*b +: 8]);
            m_cnt[ch] = m_cnt[ch] + 32'd1;
          end
          e = rev32(m_crc[ch]);
        end
        3'd4: e = m_crc[ch] ^ 32'hFFFFFFFF;
        3'd5: e = rev32(m_crc[ch]);
        3'd6: begin m_crc[ch] = rev32(d); chk = 1'b0; end
        default: begin
`ifdef CRC_CI_BYTECOUNT_EN
          e = m_cnt[ch];
`else
          e = 32'd0;
`endif
        end
      endcase
    end
    sb_q.push_back({chk, e});
  endtask

  // Drive one instruction (called at a negedge) and wait for done
  task automatic run_op(input bit use16, input logic [2:0] op, input logic [2:0] ch,
                        input logic [31:0] d, output logic [31:0] res, output int lat,
                        output bit ok);
    n     = {2'b00, ch, op};
    dataa = d;
    if (use16) start16 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    start16 = 1'b0;
    ok  = 1'b0;
    lat = 0;
    res = '0;
    while (!ok && lat < 40) begin
      @(negedge clk);
      lat++;
      if ((use16 ? done16 : done) === 1'b1) begin
        ok  = 1'b1;
        res = use16 ? result16 : result;
      end
    end
  endtask

  // ------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] res;
    logic [32:0] ex;
    int          lat;
    bit          ok;
    reset = 1'b1; clk_en = 1'b1; start = 1'b0; start16 = 1'b0; n = '0; dataa = '0;
    model_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests_run++;
    if (result !== 32'd0) begin fails++; $display("FAIL reset_result: got %h want 00000000", result); end
    reset = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      model_op(3'd5, 3'(c), 32'd0);
      run_op(1'b0, 3'd5, 3'(c), 32'd0, res, lat, ok);
      ex = sb_q.pop_front();
      tests_run++;
      if (!ok || res !== ex[31:0]) begin
        fails++; $display("FAIL reset_rdraw ch%0d: got %h (done %0d) want %h", c, res, ok, ex[31:0]);
      end
    end
    model_op(3'd7, 3'd0, 32'd0);
    run_op(1'b0, 3'd7, 3'd0, 32'd0, res, lat, ok);
    ex = sb_q.pop_front();
    tests_run++;
    if (!ok || res !== ex[31:0]) begin
      fails++; $display("FAIL reset_op7: got %h want %h", res, ex[31:0]);
    end
  endtask

  // "123456789" on ch0 with WR32/WR32/WR8, then RDFINAL and opcode 7
  task automatic test_crc32_ch0();
    logic [2:0]  ops [6] = '{3'd0, 3'd3, 3'd3, 3'd1, 3'd4, 3'd7};
    logic [31:0] ds  [6] = '{32'd0, 32'h34333231, 32'h38373635, 32'h39, 32'd0, 32'd0};
    logic [31:0] res, fin;
    logic [32:0] ex;
    int          lat;
    bit          ok;
    fin = '0;
    for (int i = 0; i < 6; i++) begin
      model_op(ops[i], 3'd0, ds[i]);
      run_op(1'b0, ops[i], 3'd0, ds[i], res, lat, ok);
      ex = sb_q.pop_front();
      if (i == 4) fin = res;
      if (ex[32] || !ok) begin
        tests_run++;
        if (!ok || res !== ex[31:0]) begin
          fails++; $display("FAIL crc32_ch0 step%0d: got %h (done %0d) want %h", i, res, ok, ex[31:0]);
        end
      end
    end
    tests_run++;
    if (fin !== 32'hCBF43926) begin fails++; $display("FAIL crc32_check: got %h want cbf43926", fin); end
  endtask

  // Same string on ch3 but split with WR16/WR8/WR16/WR32
  task automatic test_wr16_ch3();
    logic [2:0]  ops [6] = '{3'd0, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [31:0] ds  [6] = '{32'd0, 32'h3231, 32'h33, 32'h3534, 32'h39383736, 32'd0};
    logic [31:0] res, fin;
    logic [32:0] ex;
    int          lat;
    bit          ok;
    fin = '0;
    for (int i = 0; i < 6; i++) begin
      model_op(ops[i], 3'd3, ds[i]);
      run_op(1'b0, ops[i], 3'd3, ds[i], res, lat, ok);
      ex = sb_q.pop_front();
      if (i == 5) fin = res;
      if (ex[32] || !ok) begin
        tests_run++;
        if (!ok || res !== ex[31:0]) begin
          fails++; $display("FAIL wr16_ch3 step%0d: got %h (done %0d) want %h", i, res, ok, ex[31:0]);
        end
      end
    end
    tests_run++;
    if (fin !== 32'hCBF43926) begin fails++; $display("FAIL wr16_check: got %h want cbf43926", fin); end
  endtask

  task automatic test_interleave();
    logic [2:0]  ops [5] = '{3'd0, 3'd3, 3'd3, 3'd1, 3'd4};
    logic [31:0] ds  [5] = '{32'd0, 32'h34333231, 32'h38373635, 32'h39, 32'd0};
    logic [31:0] res, fin;
    logic [32:0] ex;
    int          lat;
    bit          ok;
    fin = '0;
    for (int i = 0; i < 5; i++) begin
      model_op(ops[i], 3'd1, ds[i]);
      run_op(1'b0, ops[i], 3'd1, ds[i], res, lat, ok);
      ex = sb_q.pop_front();
      if (i == 4) fin = res;
      if (ex[32] || !ok) begin
        tests_run++;
        if (!ok || res !== ex[31:0]) begin
          fails++; $display("FAIL ilv_ch1 step%0d: got %h want %h", i, res, ex[31:0]);
        end
      end
      if (i < 4) begin
        model_op(3'd3, 3'd0, 32'hDEADBEEF);
        run_op(1'b0, 3'd3, 3'd0, 32'hDEADBEEF, res, lat, ok);
        ex = sb_q.pop_front();
        tests_run++;
        if (!ok || res !== ex[31:0]) begin
          fails++; $display("FAIL ilv_ch0 step%0d: got %h want %h", i, res, ex[31:0]);
        end
      end
    end
    tests_run++;
    if (fin !== 32'hCBF43926) begin fails++; $display("FAIL ilv_check: got %h want cbf43926", fin); end
    model_op(3'd5, 3'd0, 32'd0);
    run_op(1'b0, 3'd5, 3'd0, 32'd0, res, lat, ok);
    ex = sb_q.pop_front();
    tests_run++;
    if (!ok || res !== ex[31:0]) begin fails++; $display("FAIL ilv_ch0_raw: got %h want %h", res, ex[31:0]); end
  endtask

  // ch2: partial CRC, save raw, clobber with INIT, restore with LOAD, finish
  task automatic test_save_restore();
    logic [2:0]  ops [8] = '{3'd0, 3'd3, 3'd5, 3'd0, 3'd6, 3'd3, 3'd1, 3'd4};
    logic [31:0] ds  [8] = '{32'd0, 32'h34333231, 32'd0, 32'd0, 32'd0, 32'h38373635, 32'h39, 32'd0};
    logic [31:0] res, fin, saved, d;
    logic [32:0] ex;
    int          lat;
    bit          ok;
    fin = '0;
    saved = '0;
    for (int i = 0; i < 8; i++) begin
      d = (i == 4) ? saved : ds[i];
      model_op(ops[i], 3'd2, d);
      run_op(1'b0, ops[i], 3'd2, d, res, lat, ok);
      ex = sb_q.pop_front();
      if (i == 2) saved = res;
      if (i == 7) fin = res;
      if (ex[32] || !ok) begin
        tests_run++;
        if (!ok || res !== ex[31:0]) begin
          fails++; $display("FAIL save_restore step%0d: got %h want %h", i, res, ex[31:0]);
        end
      end
    end
    tests_run++;
    if (fin !== 32'hCBF43926) begin fails++; $display("FAIL restore_check: got %h want cbf43926", fin); end
  endtask

  task automatic test_timing();
    logic [31:0] res, held;
    logic [32:0] ex;
    int          lat;
    bit          ok;
    // WR32 latency and single-cycle done
    model_op(3'd3, 3'd0, 32'h11223344);
    run_op(1'b0, 3'd3, 3'd0, 32'h11223344, res, lat, ok);
    ex = sb_q.pop_front();
    held = res;
    tests_run++;
    if (lat != 5 || !ok) begin fails++; $display("FAIL wr32_latency: got %0d want 5", lat); end
    tests_run++;
    if (res !== ex[31:0]) begin fails++; $display("FAIL wr32_result: got %h want %h", res, ex[31:0]); end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin fails++; $display("FAIL done_width: got %b want 0", done); end
    tests_run++;
    if (result !== held) begin fails++; $display("FAIL result_hold: got %h want %h", result, held); end
    // WR8 then a read issued in the done cycle
    model_op(3'd1, 3'd0, 32'hA5);
    run_op(1'b0, 3'd1, 3'd0, 32'hA5, res, lat, ok);
    ex = sb_q.pop_front();
    tests_run++;
    if (lat != 2 || res !== ex[31:0]) begin
      fails++; $display("FAIL wr8: latency %0d result %h want 2 %h", lat, res, ex[31:0]);
    end
    model_op(3'd5, 3'd0, 32'd0);
    run_op(1'b0, 3'd5, 3'd0, 32'd0, res, lat, ok);
    ex = sb_q.pop_front();
    tests_run++;
    if (lat != 1 || res !== ex[31:0]) begin
      fails++; $display("FAIL back_to_back: latency %0d result %h want 1 %h", lat, res, ex[31:0]);
    end
    // WR32 with two stalled cycles
    model_op(3'd3, 3'd0, 32'h0BADF00D);
    n = {2'b00, 3'd0, 3'd3}; dataa = 32'h0BADF00D; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ok = 1'b0; lat = 0;
    while (!ok && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) begin ok = 1'b1; res = result; end
      if (lat == 1) clk_en = 1'b0;
      if (lat == 3) clk_en = 1'b1;
    end
    clk_en = 1'b1;
    ex = sb_q.pop_front();
    tests_run++;
    if (lat != 7 || !ok) begin fails++; $display("FAIL stall_latency: got %0d want 7", lat); end
    tests_run++;
    if (res !== ex[31:0]) begin fails++; $display("FAIL stall_result: got %h want %h", res, ex[31:0]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic [32:0] ex;
    int          lat;
    bit          ok, seen;
    seen = 1'b0;
    n = {2'b00, 3'd0, 3'd3}; dataa = 32'hCAFEF00D; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk); if (done !== 1'b0) seen = 1'b1;
    @(posedge clk);
    @(negedge clk); if (done !== 1'b0) seen = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) begin @(negedge clk); if (done !== 1'b0) seen = 1'b1; end
    tests_run++;
    if (result !== 32'd0) begin fails++; $display("FAIL reset_mid_result: got %h want 0", result); end
    reset = 1'b0;
    model_reset();
    repeat (6) begin @(negedge clk); if (done !== 1'b0) seen = 1'b1; end
    tests_run++;
    if (seen) begin fails++; $display("FAIL reset_mid_done: got done pulse want none"); end
    model_op(3'd5, 3'd0, 32'd0);
    run_op(1'b0, 3'd5, 3'd0, 32'd0, res, lat, ok);
    ex = sb_q.pop_front();
    tests_run++;
    if (!ok || res !== ex[31:0]) begin fails++; $display("FAIL reset_mid_raw: got %h want %h", res, ex[31:0]); end
    model_op(3'd7, 3'd0, 32'd0);
    run_op(1'b0, 3'd7, 3'd0, 32'd0, res, lat, ok);
    ex = sb_q.pop_front();
    tests_run++;
    if (!ok || res !== ex[31:0]) begin fails++; $display("FAIL reset_mid_op7: got %h want %h", res, ex[31:0]); end
  endtask

  task automatic test_invalid_channel();
    logic [31:0] res;
    logic [32:0] ex;
    int          lat;
    bit          ok;
    // give ch0 non-reset state first so "unchanged" is meaningful
    model_op(3'd3, 3'd0, 32'h55AA55AA);
    run_op(1'b0, 3'd3, 3'd0, 32'h55AA55AA, res, lat, ok);
    ex = sb_q.pop_front();
    model_op(3'd3, 3'd5, 32'h12345678);
    run_op(1'b0, 3'd3, 3'd5, 32'h12345678, res, lat, ok);
    ex = sb_q.pop_front();
    tests_run++;
    if (lat != 5 || res !== ex[31:0]) begin
      fails++; $display("FAIL invalid_wr32: latency %0d result %h want 5 %h", lat, res, ex[31:0]);
    end
    model_op(3'd0, 3'd7, 32'd0);
    run_op(1'b0, 3'd0, 3'd7, 32'd0, res, lat, ok);
    ex = sb_q.pop_front();
    tests_run++;
    if (lat != 1 || res !== 32'd0) begin
      fails++; $display("FAIL invalid_init: latency %0d result %h want 1 00000000", lat, res);
    end
    for (int c = 0; c < 4; c++) begin
      model_op(3'd5, 3'(c), 32'd0);
      run_op(1'b0, 3'd5, 3'(c), 32'd0, res, lat, ok);
      ex = sb_q.pop_front();
      tests_run++;
      if (!ok || res !== ex[31:0]) begin
        fails++; $display("FAIL invalid_unchanged ch%0d: got %h want %h", c, res, ex[31:0]);
      end
    end
  endtask

  task automatic test_crc16();
    logic [2:0]  ops [6] = '{3'd0, 3'd3, 3'd3, 3'd1, 3'd4, 3'd5};
    logic [31:0] ds  [6] = '{32'd0, 32'h34333231, 32'h38373635, 32'h39, 32'd0, 32'd0};
    logic [31:0] res, e;
    logic [32:0] ex;
    int          lat, k;
    bit          ok, chk;
    for (int i = 0; i < 6; i++) begin
      chk = 1'b1;
      case (ops[i])
        3'd0: begin m16 = 16'hFFFF; chk = 1'b0; end
        3'd1, 3'd3: begin
          k = (ops[i] == 3'd1) ? 1 : 4;
          for (int b = 0; b < k; b++) m16 = m16_byte(m16, ds[i][8*b +: 8]);
        end
        3'd4: chk = 1'b0;
        default: ;
      endcase
      e = {16'd0, m16};
      sb_q.push_back({chk, e});
      run_op(1'b1, ops[i], 3'd0, ds[i], res, lat, ok);
      ex = sb_q.pop_front();
      if (ops[i] == 3'd4) begin
        tests_run++;
        if (!ok || res !== 32'h000029B1) begin
          fails++; $display("FAIL crc16_final: got %h want 000029b1", res);
        end
      end else if (ex[32] || !ok) begin
        tests_run++;
        if (!ok || res !== ex[31:0]) begin
          fails++; $display("FAIL crc16 step%0d: got %h want %h", i, res, ex[31:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_crc32_ch0();
    test_wr16_ch3();
    test_interleave();
    test_save_restore();
    test_timing();
    test_reset_mid();
    test_invalid_channel();
    test_crc16();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests_run %0d", tests_run);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
